// File: rtl/ofm_writer.sv
// ofm_writer: buffers systolic-array output rows in a first-word-fall-through
// FIFO and writes them to memory over a valid/ready port, generating row
// addresses as g*NO_PIXEL + r.
// Build option: define OFM_RELU_EN to clamp negative lanes to zero as rows
// enter the FIFO. Without it, rows are stored unmodified.
`timescale 1ns/1ps

module ofm_writer #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_W        = 16,
  parameter int FIFO_DEPTH    = 32,
  parameter int NO_PIXEL      = 64,
  parameter int NO_FILTER     = 16,
  parameter int ADDR_W        = 14
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            write_out_en,
  input  logic [SYSTOLIC_SIZE*DATA_W-1:0] pe_data,
  input  logic                            ctrl_done,
  output logic                            mem_wr_valid,
  input  logic                            mem_wr_ready,
  output logic [ADDR_W-1:0]               mem_wr_addr,
  output logic [SYSTOLIC_SIZE*DATA_W-1:0] mem_wr_data,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);

  localparam int ROW_W = SYSTOLIC_SIZE * DATA_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int G_NUM = (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int R_W   = (NO_PIXEL > 1) ? $clog2(NO_PIXEL) : 1;
  localparam int G_W   = (G_NUM > 1) ? $clog2(G_NUM) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, FINISH} state_t;

  state_t           state;
  logic [ROW_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [R_W-1:0]   r_cnt;
  logic [G_W-1:0]   g_cnt;
  logic [ROW_W-1:0] row_in;
  logic             collecting;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push;

  assign collecting   = (state == COLLECT) || (state == DRAIN);
  assign full         = (count == CNT_W'(FIFO_DEPTH));
  // valid comes purely from the registered occupancy, never from ready
  assign mem_wr_valid = (count != '0);
  assign pop          = mem_wr_valid && mem_wr_ready;
  assign push_req     = write_out_en && collecting;
  // a full FIFO still accepts a row when the head leaves on the same edge
  assign push         = push_req && (!full || pop);

  // head row is shown only while valid so the data bus reads zero when idle
  assign mem_wr_data  = mem_wr_valid ? fifo_mem[rd_ptr] : '0;
  assign mem_wr_addr  = ADDR_W'(g_cnt) * ADDR_W'(NO_PIXEL) + ADDR_W'(r_cnt);

`ifdef OFM_RELU_EN
  // clamp each negative lane to zero before it is stored
  always_comb begin
    row_in = pe_data;
    for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
      if (pe_data[i*DATA_W + DATA_W - 1]) row_in[i*DATA_W +: DATA_W] = '0;
    end
  end
`else
  assign row_in = pe_data;
`endif

  // row storage; contents are meaningless outside the occupied window
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= row_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // row/group address counters advance once per completed transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      g_cnt <= '0;
    end else if (state == IDLE && start) begin
      r_cnt <= '0;
      g_cnt <= '0;
    end else if (pop) begin
      if (r_cnt == R_W'(NO_PIXEL - 1)) begin
        r_cnt <= '0;
        g_cnt <= (g_cnt == G_W'(G_NUM - 1)) ? '0 : g_cnt + G_W'(1);
      end else begin
        r_cnt <= r_cnt + R_W'(1);
      end
    end
  end

  // sequencing FSM with registered busy/done and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        COLLECT: begin
          if (ctrl_done) state <= DRAIN;
        end
        DRAIN: begin
          // a row arriving on the last empty cycle keeps us draining
          if (count == '0 && !push) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
      if (push_req && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofm_writer.sv
// Testbench for ofm_writer: directed table plus hand sequences and random
// traffic, all checked every cycle against a queue-based reference model.
`timescale 1ns/1ps

module tb_ofm_writer;

  localparam int SS         = 16;
  localparam int DW         = 16;
  localparam int FD         = 32;
  localparam int NP         = 64;
  localparam int NF         = 32;
  localparam int AW         = 14;
  localparam int ROW_W      = SS * DW;
  localparam int G_NUM      = (NF + SS - 1) / SS;
  localparam int ADDR_SPAN  = G_NUM * NP;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             write_out_en = 1'b0;
  logic [ROW_W-1:0] pe_data = '0;
  logic             ctrl_done = 1'b0;
  logic             mem_wr_valid;
  logic             mem_wr_ready = 1'b0;
  logic [AW-1:0]    mem_wr_addr;
  logic [ROW_W-1:0] mem_wr_data;
  logic             busy;
  logic             done;
  logic             overflow;

  ofm_writer #(
    .SYSTOLIC_SIZE(SS), .DATA_W(DW), .FIFO_DEPTH(FD),
    .NO_PIXEL(NP), .NO_FILTER(NF), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write_out_en(write_out_en),
    .pe_data(pe_data), .ctrl_done(ctrl_done), .mem_wr_valid(mem_wr_valid),
    .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int wr_seen  = 0;

  // reference model: phase 0 idle, 1 collect, 2 drain, 3 finish
  logic [ROW_W-1:0] mq[$];
  int               m_phase = 0;
  int               m_xfers = 0;
  bit               m_ovf   = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] relu(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0] o;
    o = row;
`ifdef OFM_RELU_EN
    for (int l = 0; l < SS; l++)
      if ($signed(row[l*DW +: DW]) < 0) o[l*DW +: DW] = '0;
`endif
    return o;
  endfunction

  function automatic logic [ROW_W-1:0] make_row(input int tag);
    logic [ROW_W-1:0] o;
    for (int l = 0; l < SS; l++) o[l*DW +: DW] = {1'b0, 7'(tag), 8'(l)};
    return o;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] o;
    for (int i = 0; i < ROW_W / 32; i++) o[i*32 +: 32] = $urandom();
    return o;
  endfunction

  // drive one cycle of inputs, check current outputs, advance the model
  task automatic cycle(input logic s, input logic we, input logic cd,
                       input logic rdy, input logic [ROW_W-1:0] row);
    bit ev;
    bit push_in;
    @(posedge clk); #1;
    start = s; write_out_en = we; ctrl_done = cd; mem_wr_ready = rdy; pe_data = row;
    ev = (mq.size() > 0);
    chk1("valid", mem_wr_valid, ev);
    if (ev) begin
      chkw("data", mem_wr_data, mq[0]);
      chka("addr", mem_wr_addr, AW'(m_xfers % ADDR_SPAN));
    end
    chk1("busy", busy, m_phase != 0);
    chk1("done", done, m_phase == 3);
    chk1("overflow", overflow, m_ovf);
    if (mem_wr_valid && rdy) wr_seen++;
    if (ev && rdy) begin
      void'(mq.pop_front());
      m_xfers++;
    end
    push_in = we && (m_phase == 1 || m_phase == 2);
    if (push_in) begin
      if (mq.size() < FD) mq.push_back(relu(row));
      else m_ovf = 1'b1;
    end
    case (m_phase)
      0: if (s) begin m_phase = 1; m_ovf = 1'b0; m_xfers = 0; end
      1: if (cd) m_phase = 2;
      2: if (!ev && !push_in) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; start = 1'b0; write_out_en = 1'b0; ctrl_done = 1'b0;
    mem_wr_ready = 1'b0; pe_data = '0;
    #1;
    chk1("rst_valid", mem_wr_valid, 1'b0);
    chka("rst_addr", mem_wr_addr, '0);
    chkw("rst_data", mem_wr_data, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    mq.delete(); m_phase = 0; m_xfers = 0; m_ovf = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // end the layer with ctrl_done and let the FIFO empty out
  task automatic finish_layer();
    cycle(0, 0, 1, 1, '0);
    for (int i = 0; i < 100 && m_phase != 0; i++) cycle(0, 0, 0, 1, '0);
    chki("drain_timeout", m_phase, 0);
  endtask

  typedef struct {
    logic s, we, cd, rdy;
    int   tag;
    logic ev;
    int   eaddr;
    int   edtag;
    logic ebusy, edone, eovf;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int   w0;
    logic [ROW_W-1:0] rr;
    logic [DW-1:0]    exp_l0;

    //        s  we cd rdy tag  ev addr dtag busy done ovf
    vt[0] = '{1, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0};
    vt[1] = '{0, 1, 0, 1, 1,   0, 0, 0,   1, 0, 0};
    vt[2] = '{0, 1, 0, 1, 2,   1, 0, 1,   1, 0, 0};
    vt[3] = '{0, 1, 0, 1, 3,   1, 1, 2,   1, 0, 0};
    vt[4] = '{0, 0, 1, 1, 0,   1, 2, 3,   1, 0, 0};
    vt[5] = '{0, 0, 0, 1, 0,   0, 0, 0,   1, 0, 0};
    vt[6] = '{0, 0, 0, 1, 0,   0, 0, 0,   1, 1, 0};
    vt[7] = '{0, 1, 0, 1, 9,   0, 0, 0,   0, 0, 0};
    vt[8] = '{0, 0, 0, 1, 0,   0, 0, 0,   0, 0, 0};

    do_reset();

    // rows A,B,C in order at addr 0..2, then drain/finish, then idle push ignored
    for (int i = 0; i < 9; i++) begin
      cycle(vt[i].s, vt[i].we, vt[i].cd, vt[i].rdy, make_row(vt[i].tag));
      chk1("tbl_valid", mem_wr_valid, vt[i].ev);
      if (vt[i].ev) begin
        chka("tbl_addr", mem_wr_addr, AW'(vt[i].eaddr));
        chkw("tbl_data", mem_wr_data, make_row(vt[i].edtag));
      end
      chk1("tbl_busy", busy, vt[i].ebusy);
      chk1("tbl_done", done, vt[i].edone);
      chk1("tbl_overflow", overflow, vt[i].eovf);
    end

    // stall for 10 cycles with a row waiting, then accept
    cycle(1, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, make_row(40));
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, '0);
    w0 = wr_seen;
    cycle(0, 0, 0, 1, '0);
    chki("stall_release_writes", wr_seen - w0, 1);
    finish_layer();

    // 33 pushes into a 32-deep FIFO with ready low
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 33; i++) cycle(0, 1, 0, 0, make_row(i + 1));
    cycle(0, 0, 0, 0, '0);
    chk1("ovf_set", overflow, 1'b1);
    cycle(1, 0, 0, 0, '0);
    w0 = wr_seen;
    for (int i = 0; i < 40; i++) cycle(0, 0, 0, 1, '0);
    chki("ovf_writes", wr_seen - w0, 32);
    finish_layer();
    cycle(0, 0, 0, 1, '0);
    chk1("ovf_sticky_idle", overflow, 1'b1);
    cycle(1, 0, 0, 1, '0);
    cycle(0, 0, 0, 1, '0);
    chk1("ovf_cleared", overflow, 1'b0);
    finish_layer();

    // full FIFO accepting a push on the same edge as a pop
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 32; i++) cycle(0, 1, 0, 0, make_row(i + 50));
    cycle(0, 1, 0, 1, make_row(100));
    cycle(0, 0, 0, 0, '0);
    chk1("full_push_pop_no_ovf", overflow, 1'b0);
    w0 = wr_seen;
    finish_layer();
    chki("full_push_pop_writes", wr_seen - w0, 32);

    // 130 transfers: address wraps 0..127 then 0,1; stray start ignored
    cycle(1, 0, 0, 1, '0);
    w0 = wr_seen;
    for (int i = 0; i < 130; i++) cycle((i == 70), 1, 0, 1, rand_row());
    finish_layer();
    chki("wrap_writes", wr_seen - w0, 130);

    // ctrl_done together with the 5th row, then drain 5 rows
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, make_row(i + 60));
    cycle(0, 1, 1, 0, make_row(64));
    w0 = wr_seen;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, '0);
    chki("drain_writes", wr_seen - w0, 5);
    cycle(0, 0, 0, 1, '0);
    chk1("drain_pre_done", done, 1'b0);
    cycle(0, 0, 0, 1, '0);
    chk1("drain_done", done, 1'b1);
    chk1("drain_busy_in_finish", busy, 1'b1);
    cycle(0, 0, 0, 1, '0);
    chk1("drain_done_low", done, 1'b0);
    chk1("drain_busy_low", busy, 1'b0);

    // lane clamp behaviour
    rr = '0;
    rr[15:0]  = 16'h8001;
    rr[31:16] = 16'h7FFF;
`ifdef OFM_RELU_EN
    exp_l0 = 16'h0000;
`else
    exp_l0 = 16'h8001;
`endif
    cycle(1, 0, 0, 0, '0);
    cycle(0, 1, 0, 0, rr);
    cycle(0, 0, 0, 0, '0);
    chka("relu_valid", AW'(mem_wr_valid), AW'(1));
    chka("relu_lane0", AW'(mem_wr_data[15:0]), AW'(exp_l0));
    chki("relu_lane0_full", int'(mem_wr_data[15:0]), int'(exp_l0));
    chki("relu_lane1", int'(mem_wr_data[31:16]), 32'h7FFF);
    finish_layer();

    // reset with rows buffered discards them
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, make_row(i + 70));
    do_reset();
    w0 = wr_seen;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, '0);
    chki("post_reset_writes", wr_seen - w0, 0);

    // randomized traffic
    for (int layer = 0; layer < 4; layer++) begin
      cycle(1, 0, 0, 1, '0);
      for (int i = 0; i < 250; i++)
        cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1), 0,
              ($urandom_range(0, 9) < (layer == 1 ? 2 : 6)), rand_row());
      cycle(0, ($urandom_range(0, 1) == 1), 1, ($urandom_range(0, 1) == 1), rand_row());
      for (int i = 0; i < 200 && m_phase != 0; i++)
        cycle(0, ($urandom_range(0, 3) == 0), 0, ($urandom_range(0, 9) < 7), rand_row());
      chki("rand_drain_timeout", m_phase, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, rand_row());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
